flex_stp_deser: RTL
===================

FLEX_STP_DESER -- requirements
Module: flex_stp_deser

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, meaning parallel word width; legal values >= 2.
REQ-002 SHALL have parameter LANE_WIDTH, default 1, meaning bits shifted in per beat; must divide NUM_BITS; BEATS = NUM_BITS/LANE_WIDTH.
REQ-003 SHALL have parameter SHIFT_MSB, default 1, meaning 1 = MSB-first, 0 = LSB-first.
REQ-004 SHALL have parameter RESET_VAL, default all ones, meaning shift-register idle/reset value.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port shift_enable, input, 1 bit: accept one beat this cycle.
REQ-008 SHALL have port serial_in, input, LANE_WIDTH bits: beat data.
REQ-009 SHALL have port clear, input, 1 bit: synchronous frame resync.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the held word.
REQ-011 SHALL have port parallel_out, output, NUM_BITS bits: held completed word.
REQ-012 SHALL have port out_valid, output, 1 bit: parallel_out holds an unconsumed word.
REQ-013 SHALL have port shift_data, output, NUM_BITS bits: live shift-register contents.
REQ-014 SHALL have port beat_count, output, $clog2(BEATS) bits (min 1): beats accepted in the current word.
REQ-015 SHALL have port overrun, output, 1 bit: sticky word-dropped flag.

Function
REQ-016 SHALL, when SHIFT_MSB=1 and shift_enable=1, load {shift_data[NUM_BITS-LANE_WIDTH-1:0], serial_in}, with serial_in[LANE_WIDTH-1] the more significant bit.
REQ-017 SHALL, when SHIFT_MSB=0 and shift_enable=1, load {serial_in, shift_data[NUM_BITS-1:LANE_WIDTH]}.
REQ-018 SHALL hold shift_data and beat_count unchanged while shift_enable=0.
REQ-019 SHALL increment beat_count per accepted beat and wrap BEATS-1 -> 0.
REQ-020 SHALL mark a word complete on an accepted beat with beat_count=BEATS-1; the completing beat is included in the word.
REQ-021 SHALL implement holding FSM EMPTY (out_valid=0) / FULL (out_valid=1); parallel_out changes only on load.
REQ-022 SHALL, on completion in EMPTY, load parallel_out and enter FULL; out_valid rises the cycle after the completing edge (latency 1).
REQ-023 SHALL, in FULL with out_ready=1 and no completion, return to EMPTY on that edge.
REQ-024 SHALL, in FULL with out_ready=1 and a simultaneous completion, load the new word and remain FULL without setting overrun.
REQ-025 SHALL, in FULL with out_ready=0 and a completion, drop the new word, keep parallel_out, and set overrun.
REQ-026 SHALL keep overrun set until clear or rst.
REQ-027 SHALL, on clear=1, set shift_data=RESET_VAL, beat_count=0, out_valid=0 (EMPTY), overrun=0, and leave parallel_out unchanged.
REQ-028 SHALL give clear priority over shift_enable and out_ready in the same cycle; the beat is discarded.

Reset
REQ-029 SHALL, on rst=1 at a rising clk edge, set shift_data=RESET_VAL, parallel_out=RESET_VAL, beat_count=0, out_valid=0, overrun=0.
REQ-030 SHALL give rst priority over clear, shift_enable and out_ready; a partial word is discarded on rst mid-operation.
REQ-031 SHALL have no asynchronous reset path.

Configuration
REQ-032 SHALL, with macro FLEX_STP_DESER_PARITY_EN defined, add output word_parity (1 bit), which is the XOR of all bits of the word loaded into parallel_out.
REQ-033 SHALL update word_parity on the same edge as each parallel_out load, and reset it to the XOR of RESET_VAL.
REQ-034 SHALL, without FLEX_STP_DESER_PARITY_EN, have no word_parity port or logic, with all other behaviour identical.

Verification
REQ-035 SHALL cover NUM_BITS=8, LANE_WIDTH=1, SHIFT_MSB=1, out_ready=1, beats 0,0,0,1,0,0,1,0 -> parallel_out=8'h12, out_valid high exactly 1 cycle.
REQ-036 SHALL cover the same beats with SHIFT_MSB=0 -> parallel_out=8'h48.
REQ-037 SHALL cover LANE_WIDTH=2, SHIFT_MSB=1, beats 2'b11,2'b00,2'b10,2'b01 -> parallel_out=8'hC9 after 4 beats, beat_count sequence 1,2,3,0.
REQ-038 SHALL cover out_ready=0 with words 8'h12 then 8'hC9 -> parallel_out stays 8'h12, overrun=1; then clear -> out_valid=0, overrun=0, parallel_out=8'h12.
REQ-039 SHALL cover rst asserted after 3 beats, followed by 8 beats of 8'hC9 -> first word out is 8'hC9, shift_data=8'hFF immediately after rst.
REQ-040 SHALL cover, with FLEX_STP_DESER_PARITY_EN, word 8'h13 -> word_parity=1 and word 8'hC9 -> word_parity=0.

Source files
------------

// File: rtl/flex_stp_deser.sv
// Flexible serial-to-parallel deserializer with a one-word holding register and overrun flag.
// Optional word parity output is enabled by defining FLEX_STP_DESER_PARITY_EN.
module flex_stp_deser #(
  parameter int                  NUM_BITS   = 8,
  parameter int                  LANE_WIDTH = 1,
  parameter int                  SHIFT_MSB  = 1,
  parameter logic [NUM_BITS-1:0] RESET_VAL  = '1,
  localparam int                 BEATS      = NUM_BITS / LANE_WIDTH,
  localparam int                 CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_enable,
  input  logic [LANE_WIDTH-1:0] serial_in,
  input  logic                  clear,
  input  logic                  out_ready,
  output logic [NUM_BITS-1:0]   parallel_out,
  output logic                  out_valid,
  output logic [NUM_BITS-1:0]   shift_data,
  output logic [CNT_W-1:0]      beat_count,
  output logic                  overrun
`ifdef FLEX_STP_DESER_PARITY_EN
  ,
  output logic                  word_parity
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e                state_q, state_d;
  logic [NUM_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_BITS-1:0]   word_q, word_d;
  logic                  ovr_q, ovr_d;
  logic [NUM_BITS-1:0]   shift_next;
  logic                  word_done;
  logic                  word_load;

  // The shifted value is also the completed word when the last beat arrives.
  generate
    if (BEATS == 1) begin : g_full_lane
      assign shift_next = serial_in;
    end else if (SHIFT_MSB != 0) begin : g_msb_first
      assign shift_next = {shift_q[NUM_BITS-LANE_WIDTH-1:0], serial_in};
    end else begin : g_lsb_first
      assign shift_next = {serial_in, shift_q[NUM_BITS-1:LANE_WIDTH]};
    end
  endgenerate

  assign word_done = shift_enable && (cnt_q == LAST_BEAT);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    ovr_d     = ovr_q;
    word_load = 1'b0;

    if (clear) begin
      // Resync drops the partial word and any held word, but parallel_out keeps its value.
      shift_d = RESET_VAL;
      cnt_d   = '0;
      state_d = ST_EMPTY;
      ovr_d   = 1'b0;
    end else begin
      if (shift_enable) begin
        shift_d = shift_next;
        cnt_d   = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
        ST_EMPTY: begin
          if (word_done) begin
            word_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (word_done) word_load = 1'b1;
            else           state_d   = ST_EMPTY;
          end else if (word_done) begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase

      if (word_load) word_d = shift_next;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q <= ST_EMPTY;
      shift_q <= RESET_VAL;
      cnt_q   <= '0;
      word_q  <= RESET_VAL;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = word_q;
  assign out_valid    = (state_q == ST_FULL);
  assign shift_data   = shift_q;
  assign beat_count   = cnt_q;
  assign overrun      = ovr_q;

`ifdef FLEX_STP_DESER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst)            parity_q <= ^RESET_VAL;
    else if (word_load) parity_q <= ^shift_next;
  end

  assign word_parity = parity_q;
`endif

endmodule
